// File: rtl/nbout_pkg.sv
// nbout_pkg: shared definitions for the per-unit output neuron buffer.
//   - state_e   : FSM state encoding (IDLE / ACCUM / DRAIN)
//   - DEF_*     : default geometry (bits per value, lanes, rows, pass width)
//   - ptr_w()   : row-pointer width for a given number of buffer rows
package nbout_pkg;

  localparam int DEF_N       = 16;
  localparam int DEF_TN      = 16;
  localparam int DEF_ENTRIES = 4;
  localparam int DEF_PASS_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int ptr_w(input int entries);
    return (entries < 2) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/nbout_mem.sv
// nbout_mem: ENTRIES x W register array holding the partial-sum rows.
//   clk, rst        : clock, asynchronous active-high clear of every row
//   we_i/waddr_i/wdata_i : synchronous write port
//   fb_addr_i  -> fb_data_o : asynchronous read, feedback to the n0 unit
//   dr_addr_i  -> dr_data_o : asynchronous read, drain to the next stage
module nbout_mem #(
  parameter int W       = 256,
  parameter int ENTRIES = 4,
  parameter int AW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] fb_addr_i,
  output logic [W-1:0]  fb_data_o,
  input  logic [AW-1:0] dr_addr_i,
  output logic [W-1:0]  dr_data_o
);

  logic [W-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign fb_data_o = mem_q[fb_addr_i];
  assign dr_data_o = mem_q[dr_addr_i];

endmodule

// File: rtl/nbout_unit.sv
// nbout_unit: output neuron buffer sitting behind one n0 MAC unit.
// Captures P passes of ENTRIES result rows, feeding the stored row back as
// the partial-sum operand, then drains the finished rows downstream.
//   clk, rst                   : clock, asynchronous active-high reset
//   i_cfg_valid/i_cfg_passes   : group start request with pass count (0 => 1)
//   o_cfg_ready                : high only while idle
//   i_res_valid/i_res          : n0 result row
//   o_part_sum                 : partial-sum row presented to the n0 unit
//   o_out_valid/o_out/i_out_ready : drain handshake; a row transfers on a
//                                   cycle with valid and ready both high, and
//                                   valid/data hold steady until it does
//   o_busy                     : not idle
//   o_err                      : sticky, a result arrived outside ACCUM
module nbout_unit
  import nbout_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int Tn      = DEF_TN,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int PASS_W  = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_valid,
  input  logic [PASS_W-1:0] i_cfg_passes,
  output logic              o_cfg_ready,
  input  logic              i_res_valid,
  input  logic [Tn*N-1:0]   i_res,
  output logic [Tn*N-1:0]   o_part_sum,
  output logic              o_out_valid,
  output logic [Tn*N-1:0]   o_out,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_err
);

  localparam int W  = Tn * N;
  localparam int PW = ptr_w(ENTRIES);
  localparam logic [PW-1:0] LAST_ROW = PW'(ENTRIES - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0] p_reg_q, p_reg_d;
  logic              err_q, err_d;

  logic              wr_en;
  logic [W-1:0]      fb_data;
  logic [W-1:0]      dr_data;

  // Results are only stored while accumulating; elsewhere they are dropped.
  assign wr_en = i_res_valid && (state_q == ST_ACCUM);

  nbout_mem #(.W(W), .ENTRIES(ENTRIES), .AW(PW)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_en),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (i_res),
    .fb_addr_i (wr_ptr_q),
    .fb_data_o (fb_data),
    .dr_addr_i (rd_ptr_q),
    .dr_data_o (dr_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pass_cnt_q <= '0;
      p_reg_q    <= PASS_W'(1);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pass_cnt_q <= pass_cnt_d;
      p_reg_q    <= p_reg_d;
      err_q      <= err_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pass_cnt_d = pass_cnt_q;
    p_reg_d    = p_reg_q;
    err_d      = err_q | (i_res_valid && (state_q != ST_ACCUM));
    case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          state_d    = ST_ACCUM;
          p_reg_d    = (i_cfg_passes == '0) ? PASS_W'(1) : i_cfg_passes;
          wr_ptr_d   = '0;
          pass_cnt_d = '0;
        end
      end
      ST_ACCUM: begin
        if (i_res_valid) begin
          if (wr_ptr_q == LAST_ROW) begin
            wr_ptr_d = '0;
            if (pass_cnt_q == p_reg_q - PASS_W'(1)) begin
              state_d  = ST_DRAIN;
              rd_ptr_d = '0;
            end else begin
              pass_cnt_d = pass_cnt_q + PASS_W'(1);
            end
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (i_out_ready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_ptr_q == LAST_ROW) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: decoded from registered state only, so the feedback row never
  // depends combinationally on the incoming result.
  always_comb begin
    o_cfg_ready = (state_q == ST_IDLE);
    o_busy      = (state_q != ST_IDLE);
    o_out_valid = (state_q == ST_DRAIN);
    o_out       = (state_q == ST_DRAIN) ? dr_data : '0;
    // First pass starts from zero; later passes see the previous pass's row.
    o_part_sum  = ((state_q == ST_ACCUM) && (pass_cnt_q != '0)) ? fb_data : '0;
  end

  assign o_err = err_q;

endmodule

// File: doc/nbout_unit.md
# nbout_unit

Per-unit output neuron buffer (NBout) placed directly downstream of one n0 multiply/accumulate unit. Holds ENTRIES rows of Tn partial sums and captures each n0 result row. Feeds the stored row back as the partial-sum operand for the next accumulation pass, then drains the completed rows to the next stage over a valid/ready handshake. Addition stays in the n0 lanes; this block only stores, sequences and feeds back data.

## Interface
- N, 16, bits per value
- Tn, 16, lanes per row
- ENTRIES, 4, buffer rows; power of two, ≥2
- PASS_W, 8, width of pass-count config
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_cfg_valid  in  1  start request, carries pass count
- i_cfg_passes  in  PASS_W  accumulation passes P per group; 0 treated as 1
- o_cfg_ready  out  1  high only in IDLE
- i_res_valid  in  1  n0 result row valid this cycle
- i_res  in  Tn*N  n0 result row (lane i at [(i+1)*N-1:i*N])
- o_part_sum  out  Tn*N  partial-sum row to the n0 unit
- o_out_valid  out  1  drain row valid
- o_out  out  Tn*N  drain row
- i_out_ready  in  1  downstream accepts drain row
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  sticky: result arrived outside ACCUM

## Operation
- States IDLE, ACCUM, DRAIN. Counters: wr_ptr, rd_ptr ($clog2(ENTRIES) bits) and pass_cnt (PASS_W bits). Register P_reg.
- IDLE:
  - o_cfg_ready=1.
  - i_cfg_valid → ACCUM. P_reg=max(i_cfg_passes,1); wr_ptr=0; pass_cnt=0.
- ACCUM, on i_res_valid:
  - mem[wr_ptr]<=i_res; wr_ptr++.
  - When wr_ptr==ENTRIES-1: wr_ptr wraps to 0. If pass_cnt==P_reg-1 → DRAIN with rd_ptr=0; else pass_cnt++.
  - Without i_res_valid, nothing changes.
- o_part_sum:
  - Zero in IDLE and DRAIN.
  - Zero in ACCUM while pass_cnt==0.
  - Otherwise mem[wr_ptr], a combinational read of registers; the write path is registered, so there is no loop.
- DRAIN:
  - o_out_valid=1; o_out=mem[rd_ptr].
  - On i_out_ready: rd_ptr++. Last row (rd_ptr==ENTRIES-1) → IDLE.
- i_res_valid in IDLE or DRAIN: row dropped, memory untouched, o_err set. o_err clears only on rst.
- i_cfg_valid outside IDLE is ignored.
- Values are stored bit-exact; no arithmetic, saturation or sign handling in this block.

## Timing
- Reset values:
  - State IDLE; wr_ptr=rd_ptr=pass_cnt=0; P_reg=1; all mem rows 0; o_err=0.
  - Outputs: o_cfg_ready=1, o_busy=0, o_out_valid=0, o_part_sum=0, o_out=0.
- Config accept cycle t → ACCUM at t+1. A result at t+1 is accepted.
- Result written at edge t is visible on o_part_sum/o_out from t+1.
- Final result of the last pass at edge t → DRAIN at t+1 with o_out_valid=1. The drain path is 0-cycle from state to output.
- o_out and o_out_valid hold stable while i_out_ready=0.
- Final drain handshake at t → IDLE at t+1 with o_cfg_ready=1. There is no same-cycle reuse.
- Upstream must align each result with the o_part_sum shown in its cycle. The n0 pipeline issues a row only when the matching wr_ptr row is current.
- Asynchronous rst mid-ACCUM or mid-DRAIN abandons the group immediately: all state returns to reset values, including mem.
- Throughput: 1 result/cycle in ACCUM, 1 drain row/cycle with i_out_ready held high. Group cost = P·ENTRIES + ENTRIES cycles minimum.

## Structure
- Shared package holds:
  - State encoding (IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2).
  - Default N/Tn/ENTRIES constants.
  - A pointer-width localparam function.
- One sub-module, nbout_mem: ENTRIES×(Tn*N) register array, one synchronous write port, two asynchronous read ports (feedback, drain), async clear.
- FSM and counters live in nbout_unit.

## Test plan
- Reset: assert rst mid-cycle, then release → outputs match the reset values above, with o_cfg_ready=1 and o_part_sum=0 immediately, not at the next edge.
- P=1, lanes of row k = 16'h0010+k, rows 0..3 on consecutive cycles → o_part_sum=0 throughout; DRAIN entered one cycle after row 3; o_out shows rows 0..3 in order with i_out_ready=1; IDLE on the 5th cycle.
- P=3: pass-1 rows all 16'h0001; pass-2 rows are o_part_sum+1 → o_part_sum during pass 2 = 16'h0001 per lane, during pass 3 = 16'h0002; drained rows = 16'h0003.
- Backpressure: hold i_out_ready=0 for 3 cycles on row 1 → o_out stays row 1 and rd_ptr does not move; release → rows 1,2,3 on consecutive cycles.
- i_res_valid with 16'hDEAD during DRAIN and during IDLE → o_err=1, drained data unchanged, o_err remains set after the next config.
- i_cfg_passes=0 → behaves as P=1. rst asserted after 2 rows of a P=2 group → IDLE, mem zero, and a new P=1 group completes correctly.
